cv32e40x_rf_scoreboard: RTL and testbench

- Parametrised register-file hazard scoreboard; next generation of the controller's bypass/stall logic.
- Tracks up to DEPTH outstanding, out-of-order register writebacks: offloaded eXtension-interface instructions and multi-cycle loads.
- Generates per-read-port RAW stalls for NUM_READ_PORTS ID-stage read ports.
- Sits beside the controller FSM; its stall outputs are OR-ed into the ID-stage stall.

---
 rtl/cv32e40x_rf_scoreboard.sv | 168 ++++++++++++++++
 tb/tb_cv32e40x_rf_scoreboard.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_rf_scoreboard.sv
// Register-file RAW hazard scoreboard for out-of-order writebacks (offloaded and multi-cycle loads).
// Define CV32E40X_SCOREBOARD_WAW_EN to also block issue on a pending write to the same rd.
module cv32e40x_rf_scoreboard #(
  parameter int DEPTH          = 4,
  parameter int ID_WIDTH       = 4,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [4:0]                    issue_rd_i,
  input  logic [ID_WIDTH-1:0]           issue_id_i,
  input  logic                          commit_valid_i,
  input  logic [ID_WIDTH-1:0]           commit_id_i,
  input  logic                          commit_kill_i,
  input  logic                          retire_valid_i,
  input  logic [ID_WIDTH-1:0]           retire_id_i,
  input  logic                          flush_i,
  input  logic [NUM_READ_PORTS-1:0]     rf_re_i,
  input  logic [5*NUM_READ_PORTS-1:0]   rf_raddr_i,
  output logic [NUM_READ_PORTS-1:0]     rf_stall_o,
  output logic                          any_stall_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic                          err_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]    r_valid;
  logic [DEPTH-1:0]    r_committed;
  logic [4:0]          r_rd [DEPTH];
  logic [ID_WIDTH-1:0] r_id [DEPTH];
  logic [CNT_W-1:0]    r_count;
  logic                r_err;

  logic [DEPTH-1:0]    w_ret_hit;
  logic [DEPTH-1:0]    w_com_hit;
  logic [DEPTH-1:0]    w_alloc;
  logic                w_alloc_found;
  logic [DEPTH-1:0]    w_valid_nxt;
  logic [DEPTH-1:0]    w_committed_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                w_err_nxt;
  logic                w_issue_rec;
  logic                w_id_live;

  assign count_o = r_count;
  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign err_o   = r_err;

  // Tag matching is done against the current state only, so a retire and a
  // commit of the same tag in one cycle both hit and neither raises err.
  always_comb begin
    w_ret_hit = '0;
    w_com_hit = '0;
    w_id_live = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      w_ret_hit[e] = retire_valid_i && r_valid[e] && (r_id[e] == retire_id_i);
      w_com_hit[e] = commit_valid_i && r_valid[e] && (r_id[e] == commit_id_i);
      if (r_valid[e] && (r_id[e] == issue_id_i)) w_id_live = 1'b1;
    end
  end

`ifdef CV32E40X_SCOREBOARD_WAW_EN
  logic w_waw_hit;

  always_comb begin
    w_waw_hit = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (r_valid[e] && (r_rd[e] == issue_rd_i)) w_waw_hit = 1'b1;
    end
  end

  assign issue_ready_o = !full_o && !(w_waw_hit && (issue_rd_i != 5'd0));
`else
  // Ready comes only from the registered count, never from this cycle's retire.
  assign issue_ready_o = !full_o;
`endif

  assign w_issue_rec = issue_valid_i && issue_ready_o && (issue_rd_i != 5'd0) && !flush_i;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    w_alloc       = '0;
    w_alloc_found = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (!r_valid[e] && !w_alloc_found) begin
        w_alloc[e]    = 1'b1;
        w_alloc_found = 1'b1;
      end
    end
  end

  // Precedence per entry: retire, then kill/flush, then commit; a slot freed
  // this cycle is still seen as valid and cannot be reallocated until next cycle.
  always_comb begin
    w_valid_nxt     = r_valid;
    w_committed_nxt = r_committed;
    for (int e = 0; e < DEPTH; e++) begin
      if (r_valid[e]) begin
        if (w_ret_hit[e])                         w_valid_nxt[e] = 1'b0;
        else if (w_com_hit[e] && commit_kill_i)   w_valid_nxt[e] = 1'b0;
        else if (flush_i && !r_committed[e])      w_valid_nxt[e] = 1'b0;
        else if (w_com_hit[e])                    w_committed_nxt[e] = 1'b1;
      end else if (w_alloc[e] && w_issue_rec) begin
        w_valid_nxt[e]     = 1'b1;
        w_committed_nxt[e] = 1'b0;
      end
    end
  end

  always_comb begin
    w_count_nxt = '0;
    for (int e = 0; e < DEPTH; e++) begin
      w_count_nxt = w_count_nxt + CNT_W'(w_valid_nxt[e]);
    end
  end

  assign w_err_nxt = (commit_valid_i && (w_com_hit == '0)) ||
                     (retire_valid_i && (w_ret_hit == '0));

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_committed <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_committed <= w_committed_nxt;
      r_count     <= w_count_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // NOTE: the rd/id payload is not reset; it is only ever observed through r_valid.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (w_alloc[e] && w_issue_rec) begin
        r_rd[e] <= issue_rd_i;
        r_id[e] <= issue_id_i;
      end
    end
  end

  always_comb begin
    rf_stall_o = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (rf_re_i[p] && (rf_raddr_i[5*p +: 5] != 5'd0) &&
            r_valid[e] && (r_rd[e] == rf_raddr_i[5*p +: 5])) begin
          rf_stall_o[p] = 1'b1;
        end
      end
    end
  end

  assign any_stall_o = |rf_stall_o;

  a_no_dup_id: assert property (@(posedge clk) disable iff (!rst_n)
    w_issue_rec |-> !w_id_live);

endmodule

// File: tb/tb_cv32e40x_rf_scoreboard.sv
// Scoreboard bench for cv32e40x_rf_scoreboard: directed stimulus per cycle,
// each check() samples the DUT outputs once the cycle's inputs have settled.
module tb_cv32e40x_rf_scoreboard;

  typedef enum int {S_COUNT, S_EMPTY, S_FULL, S_READY, S_ERR, S_STALL, S_ANY} sel_e;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, commit_valid, commit_kill, retire_valid, flush;
  logic [4:0] issue_rd;
  logic [3:0] issue_id, commit_id, retire_id;
  logic [1:0] rf_re;
  logic [9:0] rf_raddr;
  logic       issue_ready, any_stall, empty, full, err;
  logic [1:0] rf_stall;
  logic [2:0] count;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  cv32e40x_rf_scoreboard #(.DEPTH(4), .ID_WIDTH(4), .NUM_READ_PORTS(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready),
    .issue_rd_i    (issue_rd),
    .issue_id_i    (issue_id),
    .commit_valid_i(commit_valid),
    .commit_id_i   (commit_id),
    .commit_kill_i (commit_kill),
    .retire_valid_i(retire_valid),
    .retire_id_i   (retire_id),
    .flush_i       (flush),
    .rf_re_i       (rf_re),
    .rf_raddr_i    (rf_raddr),
    .rf_stall_o    (rf_stall),
    .any_stall_o   (any_stall),
    .count_o       (count),
    .empty_o       (empty),
    .full_o        (full),
    .err_o         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(sel_e s);
    case (s)
      S_COUNT: return int'(count);
      S_EMPTY: return int'(empty);
      S_FULL:  return int'(full);
      S_READY: return int'(issue_ready);
      S_ERR:   return int'(err);
      S_STALL: return int'(rf_stall);
      default: return int'(any_stall);
    endcase
  endfunction

  task automatic check(input string name, input sel_e sel, input int val);
    int a;
    #1;
    a = actual(sel);
    checks++;
    if (a != val) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, a, val);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_id = 0;
    commit_valid = 0; commit_id = 0; commit_kill = 0;
    retire_valid = 0; retire_id = 0; flush = 0;
    rf_re = 0; rf_raddr = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic issue(input int rd, input int id);
    issue_valid = 1; issue_rd = 5'(rd); issue_id = 4'(id);
  endtask

  task automatic retire(input int id);
    retire_valid = 1; retire_id = 4'(id);
  endtask

  task automatic read(input int re, input int a0, input int a1);
    rf_re = 2'(re); rf_raddr = {5'(a1), 5'(a0)};
  endtask

  initial begin
    rst_n = 0;
    idle();
    @(posedge clk); #1;
    check("reset_count", S_COUNT, 0);
    check("reset_empty", S_EMPTY, 1);
    check("reset_full",  S_FULL,  0);
    check("reset_err",   S_ERR,   0);
    check("reset_ready", S_READY, 1);
    check("reset_stall", S_STALL, 0);
    step();
    rst_n = 1;

    // Basic RAW
    step(); issue(5, 1); check("raw_ready", S_READY, 1);
    step(); read(1, 5, 0);
    check("raw_stall", S_STALL, 1); check("raw_any", S_ANY, 1);
    check("raw_count1", S_COUNT, 1);
    step(); read(1, 5, 0); retire(1); check("raw_stall_retire_cyc", S_STALL, 1);
    step(); read(1, 5, 0);
    check("raw_stall_drop", S_STALL, 0); check("raw_count0", S_COUNT, 0);
    check("raw_empty", S_EMPTY, 1);

    // Fill and full
    for (int i = 0; i < 4; i++) begin
      step(); issue(i + 1, i); check("fill_ready", S_READY, 1);
    end
    step(); issue(10, 4); retire(2);
    check("full_flag", S_FULL, 1); check("full_ready_same_cyc", S_READY, 0);
    check("full_count", S_COUNT, 4);
    step(); issue(10, 4);
    check("freed_ready", S_READY, 1); check("freed_count", S_COUNT, 3);
    step(); read(3, 10, 3);
    check("refill_count", S_COUNT, 4); check("refill_full", S_FULL, 1);
    check("refill_stall", S_STALL, 1);
    step(); retire(0);
    step(); retire(1);
    step(); retire(3);
    step(); retire(4);
    step(); check("drain_count", S_COUNT, 0); check("drain_err", S_ERR, 0);

    // Flush keeps committed entries
    step(); issue(11, 0);
    step(); issue(12, 1);
    step(); issue(13, 2);
    step(); commit_valid = 1; commit_id = 1;
    step(); flush = 1; check("preflush_count", S_COUNT, 3);
    step(); read(3, 12, 11);
    check("flush_count", S_COUNT, 1); check("flush_stall_a", S_STALL, 1);
    step(); read(3, 13, 12); check("flush_stall_b", S_STALL, 2);
    step(); retire(1);
    step(); check("flush_drain", S_COUNT, 0);

    // Kill and unknown-tag error
    step(); issue(14, 3);
    step(); commit_valid = 1; commit_id = 3; commit_kill = 1;
    check("kill_pre_count", S_COUNT, 1);
    step(); check("kill_count", S_COUNT, 0); check("kill_err", S_ERR, 0);
    step(); retire(3); check("err_before", S_ERR, 0);
    step(); check("err_pulse", S_ERR, 1); check("err_count", S_COUNT, 0);
    step(); check("err_clear", S_ERR, 0);

    // Same-cycle retire and commit of one tag
    step(); issue(15, 9);
    step(); retire(9); commit_valid = 1; commit_id = 9;
    step(); check("retcom_count", S_COUNT, 0);
    step(); check("retcom_err", S_ERR, 0);

    // x0 and multi-port
    step(); issue(0, 5);
    step(); check("x0_count", S_COUNT, 0); check("x0_empty", S_EMPTY, 1);
    issue(7, 6);
    step(); read(2, 7, 7);
    check("mp_stall", S_STALL, 2); check("mp_any", S_ANY, 1);
    step(); read(0, 7, 7);
    check("mp_noen_stall", S_STALL, 0); check("mp_noen_any", S_ANY, 0);
    retire(6);
    step(); check("mp_drain", S_COUNT, 0);

    // WAW
    step(); issue(9, 7);
`ifdef CV32E40X_SCOREBOARD_WAW_EN
    step(); issue(9, 8); check("waw_block", S_READY, 0);
    step(); issue(9, 8); retire(7);
    check("waw_block_ret", S_READY, 0); check("waw_count1", S_COUNT, 1);
    step(); issue(9, 8); check("waw_ready", S_READY, 1);
    check("waw_count0", S_COUNT, 0);
    step(); check("waw_count_new", S_COUNT, 1); retire(8);
    step(); check("waw_drain", S_COUNT, 0);
`else
    step(); issue(9, 8); check("dup_ready", S_READY, 1);
    step(); read(1, 9, 0); retire(7);
    check("dup_count2", S_COUNT, 2); check("dup_stall2", S_STALL, 1);
    step(); read(1, 9, 0); retire(8);
    check("dup_count1", S_COUNT, 1); check("dup_stall1", S_STALL, 1);
    step(); read(1, 9, 0);
    check("dup_count0", S_COUNT, 0); check("dup_stall0", S_STALL, 0);
`endif

    // Asynchronous reset between clock edges
    step(); issue(20, 10);
    step(); check("pre_arst_count", S_COUNT, 1);
    step(); rst_n = 0;
    check("arst_count", S_COUNT, 0); check("arst_empty", S_EMPTY, 1);
    step(); rst_n = 1;

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
